fetch_stage: RTL and testbench

- Instruction-fetch stage of the 8-bit pipelined CPU.
- Owns the program counter and drives the combinational instruction-memory address.
- Captures the returned 16-bit instruction into the IF/ID pipeline register.
- Handles decode stalls, execute-stage redirects (taken branches/jumps) and HALT detection.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_stage_pc_gen.sv | 42 ++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined CPU: datapath widths, NOP/HALT encodings,
// fetch FSM states and small helpers used by the fetch stage.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int PERF_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR           = 16'h0000;
  localparam logic [3:0]         HALT_OPCODE_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr, input logic [3:0] opcode);
    return instr[INSTR_W-1 -: 4] == opcode;
  endfunction

  // Saturating increment: a counter pinned at all-ones stays there.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value, input logic en);
    if (en && (value != {PERF_W{1'b1}})) begin
      return value + 1'b1;
    end
    return value;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control from decode/execute, instruction memory port and IF/ID outputs.
// Optional FETCH_PERF_CNT_EN adds the performance counter outputs.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               id_stall;
  logic               ex_redirect;
  logic [PC_W-1:0]    ex_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;
  logic               halted;
`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0]  perf_fetched;
  logic [PERF_W-1:0]  perf_stall;
`endif

  // master: the fetch stage itself; slave: the surrounding core / memory.
  modport master (
    input  id_stall, ex_redirect, ex_target, imem_data,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, halted
`ifdef FETCH_PERF_CNT_EN
    , output perf_fetched, perf_stall
`endif
  );

  modport slave (
    output id_stall, ex_redirect, ex_target, imem_data,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, halted
`ifdef FETCH_PERF_CNT_EN
    , input perf_fetched, perf_stall
`endif
  );

endinterface

// File: rtl/fetch_stage_pc_gen.sv
// Program counter register and next-PC selection (redirect, stall hold, halt hold, increment).
module fetch_pc_gen
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            stall,
  input  logic            redirect,
  input  logic            halt_hit,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;

  // Outside RUN the PC is frozen; a halting capture also leaves it on the HALT address.
  always_comb begin
    pc_next = pc_reg;
    if (run) begin
      if (redirect) begin
        pc_next = target;
      end else if (!stall && !halt_hit) begin
        pc_next = pc_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: BOOT/RUN/HALTED control FSM and the IF/ID pipeline register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 8'h00,
  parameter logic [3:0]      HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_stage_if.master bus
);

  fetch_state_e       state_reg, state_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [PC_W-1:0]    ifid_pc_reg, ifid_pc_next;
  logic               valid_reg, valid_next;
  logic               halted_reg, halted_next;
  logic [PC_W-1:0]    pc;
  logic               run;
  logic               halt_hit;
  logic               capture;

  assign run      = (state_reg == RUN);
  assign halt_hit = is_halt(bus.imem_data, HALT_OPCODE);
  assign capture  = run && !bus.ex_redirect && !bus.id_stall;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .stall    (bus.id_stall),
    .redirect (bus.ex_redirect),
    .halt_hit (halt_hit),
    .target   (bus.ex_target),
    .pc       (pc)
  );

  always_comb begin
    state_next   = state_reg;
    instr_next   = instr_reg;
    ifid_pc_next = ifid_pc_reg;
    valid_next   = valid_reg;
    halted_next  = halted_reg;
    unique case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        // Redirect wins over stall and discards whatever was fetched, HALT included.
        if (bus.ex_redirect) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end else if (!bus.id_stall) begin
          instr_next   = bus.imem_data;
          ifid_pc_next = pc;
          valid_next   = 1'b1;
          if (halt_hit) begin
            state_next  = HALTED;
            halted_next = 1'b1;
          end
        end
      end
      HALTED: begin
        // The HALT stays in IF/ID until decode takes it, then only bubbles follow.
        if (!bus.id_stall) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= BOOT;
      instr_reg   <= NOP_INSTR;
      ifid_pc_reg <= '0;
      valid_reg   <= 1'b0;
      halted_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      instr_reg   <= instr_next;
      ifid_pc_reg <= ifid_pc_next;
      valid_reg   <= valid_next;
      halted_reg  <= halted_next;
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.ifid_instr = instr_reg;
  assign bus.ifid_pc    = ifid_pc_reg;
  assign bus.ifid_valid = valid_reg;
  assign bus.halted     = halted_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] fetched_reg;
  logic [PERF_W-1:0] stall_cnt_reg;
  logic              stall_event;

  // Redirect cycles are neither fetches nor stalls.
  assign stall_event = run && bus.id_stall && !bus.ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      fetched_reg   <= sat_inc(fetched_reg, capture);
      stall_cnt_reg <= sat_inc(stall_cnt_reg, stall_event);
    end
  end

  assign bus.perf_fetched = fetched_reg;
  assign bus.perf_stall   = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a cycle model.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  logic [15:0] mem [256];

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC    (8'h00),
    .HALT_OPCODE (4'hF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: 0 = boot, 1 = run, 2 = halted.
  int          m_phase;
  logic [7:0]  m_pc;
  logic [7:0]  m_ifpc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic        m_halted;
  int          m_fetched;
  int          m_stalls;

  task automatic model_reset();
    m_phase   = 0;
    m_pc      = 8'h00;
    m_ifpc    = 8'h00;
    m_instr   = 16'h0000;
    m_valid   = 1'b0;
    m_halted  = 1'b0;
    m_fetched = 0;
    m_stalls  = 0;
  endtask

  task automatic model_update(input logic s, input logic r, input logic [7:0] t);
    logic [15:0] d;
    d = mem[m_pc];
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (r) begin
        m_pc    = t;
        m_instr = 16'h0000;
        m_valid = 1'b0;
      end else if (s) begin
        if (m_stalls < 65535) m_stalls++;
      end else begin
        m_instr = d;
        m_ifpc  = m_pc;
        m_valid = 1'b1;
        if (m_fetched < 65535) m_fetched++;
        if (d[15:12] == 4'hF) begin
          m_phase  = 2;
          m_halted = 1'b1;
        end else begin
          m_pc = m_pc + 8'd1;
        end
      end
    end else begin
      if (!s) begin
        m_valid = 1'b0;
        m_instr = 16'h0000;
      end
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
  endtask

  task automatic do_reset();
    bus.id_stall    = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.ex_target   = 8'h00;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic s, input logic r, input logic [7:0] t);
    bus.id_stall    = s;
    bus.ex_redirect = r;
    bus.ex_target   = t;
    model_update(s, r, t);
    @(posedge clk);
    @(negedge clk);
    $display("[%0t] stall=%0b redir=%0b tgt=%02h -> addr=%02h instr=%04h pc=%02h v=%0b h=%0b",
             $time, s, r, t, bus.imem_addr, bus.ifid_instr, bus.ifid_pc, bus.ifid_valid, bus.halted);
  endtask

  task automatic test_reset();
    init_mem();
    rst_n = 1'b0;
    bus.id_stall = 1'b0; bus.ex_redirect = 1'b0; bus.ex_target = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.ifid_instr !== 16'h0000) begin failures++; $display("FAIL reset_instr: got %04h want 0000", bus.ifid_instr); end
    checks++; if (bus.ifid_pc !== 8'h00) begin failures++; $display("FAIL reset_ifid_pc: got %02h want 00", bus.ifid_pc); end
    checks++; if (bus.ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", bus.ifid_valid); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %0b want 0", bus.halted); end
    checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %02h want 00", bus.imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (bus.perf_fetched !== 16'd0 || bus.perf_stall !== 16'd0) begin failures++; $display("FAIL reset_perf: got %0d/%0d want 0/0", bus.perf_fetched, bus.perf_stall); end
`endif
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_valid !== 1'b0 || bus.imem_addr !== 8'h00) begin failures++; $display("FAIL boot_no_capture: got v=%0b addr=%02h want v=0 addr=00", bus.ifid_valid, bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp [4];
    init_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.ifid_instr !== exp[i] || bus.ifid_pc !== 8'(i) || bus.ifid_valid !== 1'b1) begin
        failures++;
        $display("FAIL seq_%0d: got instr=%04h pc=%02h v=%0b want instr=%04h pc=%02h v=1", i, bus.ifid_instr, bus.ifid_pc, bus.ifid_valid, exp[i], 8'(i));
      end
    end
  endtask

  task automatic test_stall();
    init_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00);
      checks++;
      if (bus.ifid_instr !== 16'h2222 || bus.ifid_pc !== 8'h01 || bus.ifid_valid !== 1'b1 || bus.imem_addr !== 8'h02) begin
        failures++;
        $display("FAIL stall_hold_%0d: got instr=%04h pc=%02h v=%0b addr=%02h want 2222/01/1/02", i, bus.ifid_instr, bus.ifid_pc, bus.ifid_valid, bus.imem_addr);
      end
    end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_instr !== 16'h3333 || bus.ifid_pc !== 8'h02) begin failures++; $display("FAIL stall_release: got %04h@%02h want 3333@02", bus.ifid_instr, bus.ifid_pc); end
  endtask

  task automatic test_redirect_stall();
    init_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'hF000; mem[8'h40] = 16'hBEEF;
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    // The HALT at address 02 is being fetched during the redirect and must be dropped.
    step(1'b1, 1'b1, 8'h40);
    checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0000) begin failures++; $display("FAIL redir_bubble: got v=%0b instr=%04h want v=0 instr=0000", bus.ifid_valid, bus.ifid_instr); end
    checks++; if (bus.imem_addr !== 8'h40) begin failures++; $display("FAIL redir_addr: got %02h want 40", bus.imem_addr); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL redir_no_halt: got %0b want 0", bus.halted); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_instr !== 16'hBEEF || bus.ifid_pc !== 8'h40 || bus.ifid_valid !== 1'b1) begin failures++; $display("FAIL redir_target: got %04h@%02h v=%0b want BEEF@40 v=1", bus.ifid_instr, bus.ifid_pc, bus.ifid_valid); end
  endtask

  task automatic test_halt();
    init_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444; mem[4] = 16'h5555; mem[5] = 16'hF000;
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    repeat (6) step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_instr !== 16'hF000 || bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 8'h05) begin failures++; $display("FAIL halt_capture: got %04h@%02h v=%0b want F000@05 v=1", bus.ifid_instr, bus.ifid_pc, bus.ifid_valid); end
    checks++; if (bus.halted !== 1'b1 || bus.imem_addr !== 8'h05) begin failures++; $display("FAIL halt_flag: got h=%0b addr=%02h want h=1 addr=05", bus.halted, bus.imem_addr); end
    step(1'b1, 1'b0, 8'h00);
    checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 16'hF000) begin failures++; $display("FAIL halt_stall_hold: got v=%0b instr=%04h want v=1 instr=F000", bus.ifid_valid, bus.ifid_instr); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0000) begin failures++; $display("FAIL halt_bubble: got v=%0b instr=%04h want v=0 instr=0000", bus.ifid_valid, bus.ifid_instr); end
    step(1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.imem_addr !== 8'h05 || bus.ifid_valid !== 1'b0 || bus.halted !== 1'b1) begin failures++; $display("FAIL halt_ignore_redir: got addr=%02h v=%0b h=%0b want 05/0/1", bus.imem_addr, bus.ifid_valid, bus.halted); end
  endtask

  task automatic test_wrap();
    init_mem();
    mem[8'hFF] = 16'hABCD;
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    checks++; if (bus.imem_addr !== 8'hFF || bus.ifid_valid !== 1'b0) begin failures++; $display("FAIL wrap_redir: got addr=%02h v=%0b want FF/0", bus.imem_addr, bus.ifid_valid); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_instr !== 16'hABCD || bus.ifid_pc !== 8'hFF || bus.imem_addr !== 8'h00) begin failures++; $display("FAIL wrap_ff: got %04h@%02h addr=%02h want ABCD@FF addr=00", bus.ifid_instr, bus.ifid_pc, bus.imem_addr); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_instr !== 16'h1000 || bus.ifid_pc !== 8'h00) begin failures++; $display("FAIL wrap_00: got %04h@%02h want 1000@00", bus.ifid_instr, bus.ifid_pc); end
  endtask

  task automatic test_async_reset();
    init_mem();
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ifid_instr !== 16'h0000 || bus.ifid_pc !== 8'h00 || bus.ifid_valid !== 1'b0 || bus.halted !== 1'b0) begin failures++; $display("FAIL async_clear: got %04h@%02h v=%0b h=%0b want 0000@00 v=0 h=0", bus.ifid_instr, bus.ifid_pc, bus.ifid_valid, bus.halted); end
    checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL async_addr: got %02h want 00", bus.imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (bus.perf_fetched !== 16'd0 || bus.perf_stall !== 16'd0) begin failures++; $display("FAIL async_perf: got %0d/%0d want 0/0", bus.perf_fetched, bus.perf_stall); end
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_valid !== 1'b0) begin failures++; $display("FAIL async_boot: got v=%0b want 0", bus.ifid_valid); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ifid_instr !== 16'h1000 || bus.ifid_pc !== 8'h00 || bus.ifid_valid !== 1'b1) begin failures++; $display("FAIL async_refetch: got %04h@%02h v=%0b want 1000@00 v=1", bus.ifid_instr, bus.ifid_pc, bus.ifid_valid); end
  endtask

  task automatic test_random();
    logic       s, r;
    logic [7:0] t;
    logic [3:0] op;
    for (int ep = 0; ep < 12; ep++) begin
      for (int i = 0; i < 256; i++) begin
        op = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        mem[i] = {op, 12'($urandom)};
      end
      do_reset();
      for (int c = 0; c < 50; c++) begin
        s = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 7) == 0);
        t = 8'($urandom_range(0, 255));
        step(s, r, t);
        checks++;
        if (bus.imem_addr !== m_pc || bus.ifid_instr !== m_instr || bus.ifid_pc !== m_ifpc ||
            bus.ifid_valid !== m_valid || bus.halted !== m_halted) begin
          failures++;
          $display("FAIL rand_e%0d_c%0d: got addr=%02h instr=%04h pc=%02h v=%0b h=%0b want addr=%02h instr=%04h pc=%02h v=%0b h=%0b",
                   ep, c, bus.imem_addr, bus.ifid_instr, bus.ifid_pc, bus.ifid_valid, bus.halted,
                   m_pc, m_instr, m_ifpc, m_valid, m_halted);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (bus.perf_fetched !== 16'(m_fetched) || bus.perf_stall !== 16'(m_stalls)) begin
          failures++;
          $display("FAIL rand_perf_e%0d_c%0d: got %0d/%0d want %0d/%0d", ep, c, bus.perf_fetched, bus.perf_stall, m_fetched, m_stalls);
        end
`endif
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
